// File: rtl/mmio_responder_if.sv
// mmio_responder_if: core data-port bus and TX byte stream of the MMIO responder.
interface mmio_responder_if;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic        en;
    logic [31:0] dout;
    logic        hit_q;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    modport master (output addr, din, we, en, tx_ready, input dout, hit_q, tx_data, tx_valid);
    modport slave  (input addr, din, we, en, tx_ready, output dout, hit_q, tx_data, tx_valid);
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: game I/O window (flap latch, frame counter, score, TX FIFO) on the SUBLEQ data port.
// The TX FIFO, TX/CLR registers and STATUS bits 1-3 exist only when MMIO_TX_FIFO_EN is defined.
module mmio_responder #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FFF0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flap_btn,
    input  logic            i_vsync_tick,
    mmio_responder_if.slave bus
);
    logic        w_in_win, w_rd, w_wr, w_flap_edge;
    logic        w_full, w_empty, w_tx_ovf;
    logic [3:0]  w_off;
    logic [31:0] w_rdata;
    logic [2:0]  r_sync;
    logic        r_flap_pending, r_hit_q;
    logic [31:0] r_frame, r_score, r_dout;

    assign w_in_win    = bus.en && (bus.addr[31:4] == IO_BASE[31:4]);
    assign w_off       = bus.addr[3:0];
    assign w_rd        = w_in_win && !bus.we;
    assign w_wr        = w_in_win && bus.we;
    // r_sync[1:0] is the synchronizer, r_sync[2] the edge-detect history
    assign w_flap_edge = r_sync[1] && !r_sync[2];

    always_comb begin
        w_rdata = '0;
        case (w_off)
            4'h0:    w_rdata = {28'b0, w_tx_ovf, w_empty, w_full, r_flap_pending};
            4'h1:    w_rdata = {31'b0, r_flap_pending};
            4'h2:    w_rdata = r_frame;
            4'h4:    w_rdata = r_score;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync         <= '0;
            r_flap_pending <= 1'b0;
            r_frame        <= '0;
            r_score        <= '0;
            r_dout         <= '0;
            r_hit_q        <= 1'b0;
        end else begin
            r_sync  <= {r_sync[1:0], i_flap_btn};
            r_hit_q <= w_rd;
            if (w_rd)
                r_dout <= w_rdata;
            if (w_flap_edge)
                r_flap_pending <= 1'b1;
            else if (w_rd && w_off == 4'h1)
                r_flap_pending <= 1'b0;
            if (w_wr && w_off == 4'h2)
                r_frame <= bus.din;
            else if (i_vsync_tick)
                r_frame <= r_frame + 32'd1;
            if (w_wr && w_off == 4'h4)
                r_score <= bus.din;
        end
    end

    assign bus.dout  = r_dout;
    assign bus.hit_q = r_hit_q;

`ifdef MMIO_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        r_tx_ovf, w_push_req, w_pop, w_push;

    assign w_full       = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_empty      = r_wp == r_rp;
    assign w_pop        = !w_empty && bus.tx_ready;
    assign w_push_req   = w_wr && w_off == 4'h3;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_tx_ovf     = r_tx_ovf;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_push_req && !w_push)
                r_tx_ovf <= 1'b1;
            else if (w_wr && w_off == 4'h5 && bus.din[0])
                r_tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= bus.din[7:0];
`else
    logic w_unused_tx_ready;
    assign w_unused_tx_ready = bus.tx_ready;
    assign w_full            = 1'b0;
    assign w_empty           = 1'b1;
    assign w_tx_ovf          = 1'b0;
    assign bus.tx_valid      = 1'b0;
    assign bus.tx_data       = 8'h00;
`endif
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: table vectors, directed corner sequences and random traffic against a reference model.
module tb_mmio_responder;
`ifdef MMIO_TX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF0;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        bit          we;
        bit          en;
        bit          tick;
        logic [31:0] dout;
        bit          hit;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1, flap_btn = 1'b0, vsync_tick = 1'b0;
    int   n_vec = 0, n_err = 0;

    mmio_responder_if bus();
    mmio_responder #(.IO_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_flap_btn(flap_btn), .i_vsync_tick(vsync_tick), .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_frame, m_score, m_dout;
    bit          m_pend, m_hit, m_ovf, h1, h2, h3;
    logic [7:0]  q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_frame = 0; m_score = 0; m_dout = 0;
        m_pend = 0; m_hit = 0; m_ovf = 0;
        h1 = 0; h2 = 0; h3 = 0;
        q.delete();
    endfunction

    function automatic void model_edge();
        logic [3:0]  off;
        logic [31:0] rv;
        bit win, rd, wr, pop, rise;
        off  = bus.addr[3:0];
        win  = bus.en && bus.addr >= BASE;
        rd   = win && !bus.we;
        wr   = win && bus.we;
        pop  = q.size() > 0 && bus.tx_ready;
        // button level sampled two edges ago rose relative to three edges ago
        rise = h2 && !h3;
        case (off)
            4'h0:    rv = {28'b0, m_ovf, q.size() == 0, q.size() == DEPTH, m_pend};
            4'h1:    rv = {31'b0, m_pend};
            4'h2:    rv = m_frame;
            4'h4:    rv = m_score;
            default: rv = 0;
        endcase
        m_hit = rd;
        if (rd) m_dout = rv;
        h3 = h2; h2 = h1; h1 = flap_btn;
        if (rise) m_pend = 1;
        else if (rd && off == 4'h1) m_pend = 0;
        if (wr && off == 4'h2) m_frame = bus.din;
        else if (vsync_tick) m_frame = m_frame + 1;
        if (wr && off == 4'h4) m_score = bus.din;
        if (FIFO_EN) begin
            if (pop) void'(q.pop_front());
            if (wr && off == 4'h3) begin
                if (q.size() < DEPTH) q.push_back(bus.din[7:0]);
                else m_ovf = 1;
            end
            if (wr && off == 4'h5 && bus.din[0]) m_ovf = 0;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_dout"}, bus.dout, m_dout);
        chk({tag, "_hit_q"}, {31'b0, bus.hit_q}, {31'b0, m_hit});
        chk({tag, "_tx_valid"}, {31'b0, bus.tx_valid}, {31'b0, q.size() > 0});
        chk({tag, "_tx_data"}, {24'b0, bus.tx_data}, q.size() > 0 ? {24'b0, q[0]} : 32'h0);
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit w, input bit e, input bit t);
        bus.addr = a; bus.din = d; bus.we = w; bus.en = e; vsync_tick = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic rd(input logic [3:0] off);
        cycle(BASE + {28'b0, off}, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // called at a falling clock edge; reset is asserted asynchronously and held 3 cycles with traffic
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (3) begin
            bus.addr = $urandom; bus.din = $urandom; bus.we = 1'($urandom_range(0, 1));
            bus.en = 1'b1; vsync_tick = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_outputs("rst_hold");
        end
        bus.en = 1'b0; vsync_tick = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input bit push99, input bq_t exp);
        bq_t got;
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (bus.tx_valid) got.push_back(bus.tx_data);
            if (k == 0 && push99) cycle(BASE + 3, 32'h99, 1'b1, 1'b1, 1'b0);
            else idle();
        end
        bus.tx_ready = 1'b0;
        chk("drain_count", got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            chk("drain_byte", {24'b0, got[k]}, {24'b0, exp[k]});
        chk("drain_empty", {31'b0, bus.tx_valid}, 32'h0);
    endtask

    initial begin
        vec_t tbl[19];
        bq_t  e;
        logic [31:0] a;
        tbl[0]  = '{32'hFFFF_FFF4, 32'hDEAD_BEEF, 1, 1, 0, 32'h4,         0};
        tbl[1]  = '{32'hFFFF_FFEF, 32'h5,         1, 1, 0, 32'h4,         0};
        tbl[2]  = '{32'hFFFF_FFF4, 32'h0,         0, 1, 0, 32'hDEAD_BEEF, 1};
        tbl[3]  = '{32'hFFFF_FFEF, 32'h0,         0, 1, 0, 32'hDEAD_BEEF, 0};
        tbl[4]  = '{32'hFFFF_FFF2, 32'hFFFF_FFFE, 1, 1, 0, 32'hDEAD_BEEF, 0};
        tbl[5]  = '{32'hFFFF_FFF2, 32'h0,         0, 1, 0, 32'hFFFF_FFFE, 1};
        tbl[6]  = '{32'hFFFF_FFF2, 32'h0,         0, 0, 1, 32'hFFFF_FFFE, 0};
        tbl[7]  = '{32'hFFFF_FFF2, 32'h0,         0, 0, 1, 32'hFFFF_FFFE, 0};
        tbl[8]  = '{32'hFFFF_FFF2, 32'h0,         0, 1, 0, 32'h0,         1};
        tbl[9]  = '{32'hFFFF_FFF2, 32'h7,         1, 1, 1, 32'h0,         0};
        tbl[10] = '{32'hFFFF_FFF2, 32'h0,         0, 1, 0, 32'h7,         1};
        tbl[11] = '{32'hFFFF_FFFF, 32'h0,         0, 1, 0, 32'h0,         1};
        tbl[12] = '{32'hFFFF_FFF4, 32'h0,         1, 0, 0, 32'h0,         0};
        tbl[13] = '{32'hFFFF_FFF4, 32'h0,         0, 1, 0, 32'hDEAD_BEEF, 1};
        tbl[14] = '{32'hFFFF_FFF3, 32'h0,         0, 1, 0, 32'h0,         1};
        tbl[15] = '{32'h0000_0004, 32'h1,         1, 1, 0, 32'h0,         0};
        tbl[16] = '{32'hFFFF_FFF4, 32'h0,         0, 1, 0, 32'hDEAD_BEEF, 1};
        tbl[17] = '{32'hFFFF_FFF5, 32'h0,         0, 1, 0, 32'h0,         1};
        tbl[18] = '{32'hFFFF_FFF1, 32'h0,         0, 1, 0, 32'h0,         1};

        bus.addr = 0; bus.din = 0; bus.we = 0; bus.en = 0; bus.tx_ready = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        rd(4'h0);
        chk("status_after_reset", bus.dout, 32'h4);

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].addr, tbl[i].din, tbl[i].we, tbl[i].en, tbl[i].tick);
            chk("tbl_dout", bus.dout, tbl[i].dout);
            chk("tbl_hit_q", {31'b0, bus.hit_q}, {31'b0, tbl[i].hit});
        end

        // flap pulse, then read-to-clear
        flap_btn = 1'b1;
        repeat (3) idle();
        flap_btn = 1'b0;
        rd(4'h0); chk("flap_status", bus.dout, 32'h5);
        rd(4'h1); chk("flap_read1", bus.dout, 32'h1);
        rd(4'h1); chk("flap_read0", bus.dout, 32'h0);
        // edge lands on the same edge as a FLAP read: old value returned, set wins
        flap_btn = 1'b1;
        idle(); idle();
        rd(4'h1); chk("flap_coincident_read", bus.dout, 32'h0);
        flap_btn = 1'b0;
        rd(4'h0); chk("flap_coincident_status", bus.dout, 32'h5);
        rd(4'h1);

        // overflow with consumer stalled
        for (int i = 1; i <= 5; i++) cycle(BASE + 3, 32'(i * 17), 1'b1, 1'b1, 1'b0);
        rd(4'h0); chk("fifo_status", bus.dout, FIFO_EN ? 32'hA : 32'h4);
        chk("fifo_head", {24'b0, bus.tx_data}, FIFO_EN ? 32'h11 : 32'h0);
        cycle(BASE + 5, 32'h1, 1'b1, 1'b1, 1'b0);
        rd(4'h0); chk("clr_status", bus.dout, FIFO_EN ? 32'h2 : 32'h4);
        if (FIFO_EN) e = '{8'h11, 8'h22, 8'h33, 8'h44}; else e = {};
        drain(1'b0, e);

        // push into a full FIFO while the head pops
        for (int i = 1; i <= 4; i++) cycle(BASE + 3, 32'(i), 1'b1, 1'b1, 1'b0);
        if (FIFO_EN) e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h99}; else e = {};
        drain(1'b1, e);
        rd(4'h0); chk("pushpop_status", bus.dout, 32'h4);

        // reset with bytes queued
        cycle(BASE + 3, 32'hAB, 1'b1, 1'b1, 1'b0);
        cycle(BASE + 3, 32'hCD, 1'b1, 1'b1, 1'b0);
        do_reset();
        rd(4'h0); chk("status_after_midreset", bus.dout, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) flap_btn = ~flap_btn;
            bus.tx_ready = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + $urandom_range(0, 7);
            cycle(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            if (i == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
